// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_BITS            = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus received-byte outputs of the UART receiver.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (input rx, output data_out, data_valid, frame_err, busy);
  modport slave  (output rx, input data_out, data_valid, frame_err, busy);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async rx line plus a delayed copy for edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_m;
  logic rx_s_d;

  // All flops reset to the idle-line level so release never looks like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 3-sample majority vote at the bit centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.master bus
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_S2   = CW'(HALF + 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (bus.rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  rx_state_t            state, state_nxt;
  logic [CW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [1:0]           samp, samp_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 valid_q, valid_nxt;
  logic                 err_q, err_nxt;
  logic                 majority;
  logic                 wrap;
  logic                 centre;

  // The third sample is the live rx_s, so the vote resolves at HALF+1
  assign majority = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign wrap     = (bit_cnt == CNT_LAST);
  assign centre   = (bit_cnt == CNT_S2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      samp    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      samp    <= samp_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
    end
  end

  // STOP returns to IDLE at the vote, leaving half a bit to catch the next start edge
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = wrap ? '0 : bit_cnt + CW'(1);
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    samp_nxt    = samp;
    data_nxt    = data_q;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;

    if (bit_cnt == CNT_S0) samp_nxt[0] = rx_s;
    if (bit_cnt == CNT_S1) samp_nxt[1] = rx_s;

    case (state)
      IDLE: begin
        bit_cnt_nxt = '0;
        bit_idx_nxt = '0;
        if (fall) state_nxt = START;
      end
      START: begin
        if (centre && majority) begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
        end else if (wrap) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (centre) shift_nxt[bit_idx] = majority;
        if (wrap) begin
          if (bit_idx == 3'(DATA_BITS - 1)) state_nxt = STOP;
          else bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (centre) begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
          if (majority) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end of the UART datapath. Recovers 8N1 frames from the asynchronous `rx` line, checks the start and stop bits, and presents each received byte on `data_out` with a one-cycle `data_valid` strobe. Its output feeds the 16-byte packing buffer directly downstream, which loads `data_out` only in cycles where `data_valid` is high.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit period (100 MHz / 115200). Legal values are ≥ 8.
- `clk` input 1: system clock. All state is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx` input 1: asynchronous serial line, idle high.
- `data_out` output 8: last correctly framed byte. Holds its value between frames.
- `data_valid` output 1: one-cycle pulse when `data_out` updates.
- `frame_err` output 1: one-cycle pulse when the stop bit samples 0.
- `busy` output 1: high in every state except IDLE.

## Operation
- **Input synchronisation**
  - `rx` passes through a 2-flop synchronizer to give `rx_s`.
  - A third flop gives `rx_s_d`, used for falling-edge detection.
- **Constants**
  - `HALF = CLKS_PER_BIT/2`, integer division.
  - `bit_cnt` counts 0..CLKS_PER_BIT-1 and wraps to 0 at the end of each bit period.
- **Majority vote**
  - `rx_s` is sampled at `bit_cnt` = HALF-1, HALF and HALF+1.
  - The bit value is the majority of those 3 samples, resolved at HALF+1.
- **State machine**
  - IDLE: `bit_cnt` = 0. On `rx_s`=0 and `rx_s_d`=1, go to START.
  - START: at HALF+1, a majority of 1 is a false start and returns to IDLE. Otherwise stay until the wrap, then go to DATA with `bit_idx` = 0.
  - DATA: at HALF+1, the majority goes into shift register bit `bit_idx` (LSB first). At the wrap, increment `bit_idx`; after bit 7, go to STOP.
  - STOP: at HALF+1, resolve the stop bit, then go to IDLE immediately rather than waiting for the wrap. This leaves half a bit of margin to resynchronise on the next start edge.
- **Stop-bit outcome**
  - Majority 1: `data_out` ← shift register and `data_valid` pulses.
  - Majority 0: `frame_err` pulses and `data_out` is unchanged.
- **Line held low (break)**: IDLE requires a falling edge to start, so a line held low after a framing error does not retrigger reception.
- **Reset values**: `data_out`=0x00, `data_valid`=0, `frame_err`=0, `busy`=0, state IDLE, all counters 0, synchronizer flops 1.
- **Reset mid-frame**: the partial byte is discarded and no pulse is issued. After release, reception resumes only on a fresh falling edge.
- `data_valid` and `frame_err` are never high in the same cycle.

## Timing
- **Reference cycle T0**: the cycle in which IDLE sees the falling edge on `rx_s`. `rx_s` lags `rx` by 2 cycles.
- **Decision point**: the decision for bit n (start = 0, data = 1..8, stop = 9) is made at cycle T0 + 1 + n·CLKS_PER_BIT + HALF + 1.
- **Output latency**
  - `data_valid` or `frame_err` is high in cycle T0 + 9·CLKS_PER_BIT + HALF + 3, for exactly 1 cycle.
  - `data_out` changes in that same cycle.
- **`busy`**: rises the cycle after T0 and falls in the same cycle as the stop outcome.
- **Back-to-back frames**: a start bit arriving right after the stop bit is accepted.
- **Baud tolerance**: transmitter rate mismatch up to ±3 % must be tolerated.
- **Throughput**: one byte per 10 bit periods maximum. There is no backpressure; the downstream stage must accept every `data_valid`.

## Structure
- **Package `uart_pkg`**
  - State enum: IDLE, START, DATA, STOP.
  - `DEFAULT_CLKS_PER_BIT`.
  - `DATA_BITS` = 8.
- **Sub-module `uart_rx_sync`**
  - 2-flop synchronizer plus the edge-detect flop.
  - Outputs `rx_s` and `fall`.
  - Reset value 1 on all flops.
- **Counter sizing**: the bit-period counter width is `$clog2(CLKS_PER_BIT)`. `bit_idx` is 3 bits.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- **Single frame**: send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) → `data_valid` is a single pulse at T0+155, `data_out`=0xA5, `frame_err` stays 0.
- **Back-to-back frames**: send 0x00 then 0xFF with no idle gap → two `data_valid` pulses 160 cycles apart, `data_out` 0x00 then 0xFF.
- **False start**: `rx` low for 4 cycles, then high → FSM returns to IDLE, no `data_valid`, no `frame_err`, `busy` high for 10 cycles.
- **Framing error**: send 0x3C with the stop bit forced 0 → `frame_err` pulses once and `data_out` keeps its previous value 0xFF. A following good 0x81 frame is received correctly.
- **Noise rejection**: in 0x55, invert `rx` for 1 cycle at the centre sample of bit 3 → `data_out`=0x55 via the majority vote.
- **Reset mid-frame**: assert `rst` for 1 cycle during bit 4 of 0x12, then send 0x34 → only one `data_valid`, with `data_out`=0x34. All outputs read their reset values while `rst` is high.
